// File: rtl/rr_encoder_pkg.sv
// Shared types and helpers for the round-robin encoder.
package rr_encoder_pkg;

  // Output slot occupancy; valid_o is a decode of this state.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Widest supported index width; onehot() results are sized to cover it.
  localparam int unsigned MaxInputSize = 8;
  localparam int unsigned MaxReqWidth  = 1 << MaxInputSize;

  // One-hot vector with bit idx set; all-zero when idx falls outside width.
  function automatic logic [MaxReqWidth-1:0] onehot(input int unsigned idx,
                                                    input int unsigned width);
    logic [MaxReqWidth-1:0] one;
    one = MaxReqWidth'(1);
    if (idx < width) begin
      return one << idx;
    end
    return '0;
  endfunction

endpackage

// File: rtl/rr_encoder_if.sv
// Request/grant bus between requesters, the encoder and the index consumer.
interface rr_encoder_if #(
  parameter int unsigned InputSize = 5
);

  logic [(1<<InputSize)-1:0] req_i;
  logic [InputSize-1:0]      index_o;
  logic                      valid_o;
  logic                      ready_i;
  logic [(1<<InputSize)-1:0] ack_o;

  // Requesters and index consumer side.
  modport master (
    output req_i,
    output ready_i,
    input  index_o,
    input  valid_o,
    input  ack_o
  );

  // Encoder side.
  modport slave (
    input  req_i,
    input  ready_i,
    output index_o,
    output valid_o,
    output ack_o
  );

endinterface

// File: rtl/rr_encoder_priority_encoder.sv
// Combinational lowest-set-bit-first encoder.
module priority_encoder #(
  parameter int unsigned InputSize = 5
) (
  input  logic [(1<<InputSize)-1:0] data_i,
  output logic [InputSize-1:0]      data_o,
  output logic                      found_o
);

  localparam int unsigned Width = 1 << InputSize;

  // Scan upward; the first set bit wins and later bits are ignored.
  always_comb begin
    data_o  = '0;
    found_o = 1'b0;
    for (int unsigned i = 0; i < Width; i++) begin
      if (!found_o && data_i[i]) begin
        data_o  = InputSize'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_encoder.sv
// Round-robin 2^n-to-n encoder with a registered valid/ready index slot
// and a one-cycle one-hot acknowledge back to the winning requester.
module rr_encoder
  import rr_encoder_pkg::*;
#(
  parameter int unsigned InputSize = 5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  rr_encoder_if.slave bus
);

  localparam int unsigned ReqWidth = 1 << InputSize;

  state_t                 state;
  logic [InputSize-1:0]   ptr;
  logic [InputSize-1:0]   index_q;
  logic [ReqWidth-1:0]    ack_q;

  logic                   cap;
  logic [ReqWidth-1:0]    eff;
  logic [2*ReqWidth-1:0]  eff_dbl;
  logic [ReqWidth-1:0]    eff_rot;
  logic [InputSize-1:0]   enc_idx;
  logic                   found;
  logic [InputSize-1:0]   winner;
  logic [MaxReqWidth-1:0] ack_full;
  logic [ReqWidth-1:0]    ack_next;

  // Capture whenever the slot is free or is being consumed this cycle.
  assign cap = (state == EMPTY) | ((state == FULL) & bus.ready_i);

  // The requester being acked cannot have dropped req yet, so mask it out.
  assign eff = bus.req_i & ~ack_q;

  // Rotate right by ptr so the encoder's bit 0 is the highest-priority line;
  // the doubled vector makes the wrap-around a plain shift.
  assign eff_dbl = {eff, eff} >> ptr;
  assign eff_rot = eff_dbl[ReqWidth-1:0];

  priority_encoder #(
    .InputSize (InputSize)
  ) u_prio (
    .data_i  (eff_rot),
    .data_o  (enc_idx),
    .found_o (found)
  );

  // Undo the rotation; InputSize-bit addition gives the mod 2^n wrap.
  assign winner   = enc_idx + ptr;
  assign ack_full = onehot(32'(winner), ReqWidth);
  assign ack_next = ack_full[ReqWidth-1:0];

  // Slot state, rotating pointer, held index and single-cycle ack pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= EMPTY;
      ptr     <= '0;
      index_q <= '0;
      ack_q   <= '0;
    end else begin
      ack_q <= '0;
      if (cap) begin
        if (found) begin
          state   <= FULL;
          index_q <= winner;
          ack_q   <= ack_next;
          ptr     <= winner + InputSize'(1);
        end else begin
          state <= EMPTY;
        end
      end
    end
  end

  assign bus.index_o = index_q;
  assign bus.valid_o = (state == FULL);
  assign bus.ack_o   = ack_q;

endmodule

// File: tb/tb_rr_encoder.sv
// Directed bench for rr_encoder: an InputSize=3 instance for most scenarios
// and an InputSize=5 instance for the single-hot decode-inverse sweep.
module tb_rr_encoder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rr_encoder_if #(.InputSize(3)) bus3 ();
  rr_encoder_if #(.InputSize(5)) bus5 ();

  rr_encoder #(.InputSize(3)) dut3 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus3)
  );

  rr_encoder #(.InputSize(5)) dut5 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus3.req_i   = '0;
    bus3.ready_i = 1'b0;
    bus5.req_i   = '0;
    bus5.ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus3.valid_o !== 1'b0 || bus3.index_o !== 3'd0 || bus3.ack_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_initial: valid=%b index=%0d ack=%h, want 0/0/00",
               bus3.valid_o, bus3.index_o, bus3.ack_o);
    end
    bus3.req_i   = 8'h10;
    bus3.ready_i = 1'b0;
    tick();
    checks++;
    if (bus3.valid_o !== 1'b1 || bus3.index_o !== 3'd4) begin
      errors++;
      $display("FAIL reset_prefill: valid=%b index=%0d, want 1/4",
               bus3.valid_o, bus3.index_o);
    end
    // Assert reset mid-cycle while the slot is full.
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus3.valid_o !== 1'b0 || bus3.index_o !== 3'd0 || bus3.ack_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_async: valid=%b index=%0d ack=%h, want 0/0/00",
               bus3.valid_o, bus3.index_o, bus3.ack_o);
    end
    @(posedge clk);
    #1;
    bus3.req_i = '0;
    rst_n      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus3.valid_o !== 1'b0 || bus3.index_o !== 3'd0 || bus3.ack_o !== 8'h00) begin
        errors++;
        $display("FAIL reset_idle[%0d]: valid=%b index=%0d ack=%h, want 0/0/00",
                 i, bus3.valid_o, bus3.index_o, bus3.ack_o);
      end
    end
  endtask

  task automatic test_rotation();
    int exp_idx [8];
    logic [7:0] one8;
    logic [7:0] exp_ack;
    exp_idx = '{1, 2, 5, 7, 1, 2, 5, 7};
    one8    = 8'h01;
    do_reset();
    bus3.req_i   = 8'b1010_0110;
    bus3.ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_ack = one8 << exp_idx[i];
      checks++;
      if (bus3.valid_o !== 1'b1 || bus3.index_o !== 3'(exp_idx[i]) || bus3.ack_o !== exp_ack) begin
        errors++;
        $display("FAIL rotation[%0d]: valid=%b index=%0d ack=%h, want 1/%0d/%h",
                 i, bus3.valid_o, bus3.index_o, bus3.ack_o, exp_idx[i], exp_ack);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_ack;
    do_reset();
    bus3.req_i   = 8'b0001_0000;
    bus3.ready_i = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      exp_ack = (i == 0) ? 8'b0001_0000 : 8'h00;
      checks++;
      if (bus3.valid_o !== 1'b1 || bus3.index_o !== 3'd4 || bus3.ack_o !== exp_ack) begin
        errors++;
        $display("FAIL backpressure[%0d]: valid=%b index=%0d ack=%h, want 1/4/%h",
                 i, bus3.valid_o, bus3.index_o, bus3.ack_o, exp_ack);
      end
      // Winner drops; new requests appear but must be ignored while stalled.
      bus3.req_i = 8'h03;
      if (i < 4) tick();
    end
    bus3.ready_i = 1'b1;
    tick();
    // Pointer sits at 5, so the wrap reaches bit 0 first.
    checks++;
    if (bus3.valid_o !== 1'b1 || bus3.index_o !== 3'd0 || bus3.ack_o !== 8'h01) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b index=%0d ack=%h, want 1/0/01",
               bus3.valid_o, bus3.index_o, bus3.ack_o);
    end
  endtask

  task automatic test_drop_after_ack();
    logic       exp_valid [4];
    int         exp_idx   [4];
    logic [7:0] exp_ack   [4];
    logic [7:0] next_req  [4];
    int         ack0_cnt;
    int         ack7_cnt;
    exp_valid = '{1'b1, 1'b1, 1'b0, 1'b0};
    exp_idx   = '{0, 7, 0, 0};
    exp_ack   = '{8'h01, 8'h80, 8'h00, 8'h00};
    next_req  = '{8'h80, 8'h00, 8'h00, 8'h00};
    ack0_cnt  = 0;
    ack7_cnt  = 0;
    do_reset();
    bus3.req_i   = 8'h81;
    bus3.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus3.ack_o[0]) ack0_cnt++;
      if (bus3.ack_o[7]) ack7_cnt++;
      checks++;
      if (bus3.valid_o !== exp_valid[i] || bus3.ack_o !== exp_ack[i] ||
          (exp_valid[i] && bus3.index_o !== 3'(exp_idx[i]))) begin
        errors++;
        $display("FAIL drop_after_ack[%0d]: valid=%b index=%0d ack=%h, want %b/%0d/%h",
                 i, bus3.valid_o, bus3.index_o, bus3.ack_o,
                 exp_valid[i], exp_idx[i], exp_ack[i]);
      end
      bus3.req_i = next_req[i];
    end
    checks++;
    if (ack0_cnt != 1 || ack7_cnt != 1) begin
      errors++;
      $display("FAIL drop_ack_count: ack0=%0d ack7=%0d, want 1/1", ack0_cnt, ack7_cnt);
    end
  endtask

  task automatic test_decode_inverse();
    logic [31:0] one32;
    logic [31:0] hot;
    one32 = 32'h1;
    do_reset();
    bus5.ready_i = 1'b1;
    for (int k = 0; k < 32; k++) begin
      hot        = one32 << k;
      bus5.req_i = hot;
      tick();
      checks++;
      if (bus5.valid_o !== 1'b1 || bus5.index_o !== 5'(k) || bus5.ack_o !== hot) begin
        errors++;
        $display("FAIL decode_inverse[%0d]: valid=%b index=%0d ack=%h, want 1/%0d/%h",
                 k, bus5.valid_o, bus5.index_o, bus5.ack_o, k, hot);
      end
      bus5.req_i = '0;
      tick();
      checks++;
      if (bus5.valid_o !== 1'b0 || bus5.ack_o !== 32'h0) begin
        errors++;
        $display("FAIL decode_empty[%0d]: valid=%b ack=%h, want 0/0",
                 k, bus5.valid_o, bus5.ack_o);
      end
    end
  endtask

  task automatic test_accept_capture();
    do_reset();
    bus3.req_i   = 8'b0000_1000;
    bus3.ready_i = 1'b0;
    tick();
    checks++;
    if (bus3.valid_o !== 1'b1 || bus3.index_o !== 3'd3 || bus3.ack_o !== 8'h08) begin
      errors++;
      $display("FAIL accept_setup: valid=%b index=%0d ack=%h, want 1/3/08",
               bus3.valid_o, bus3.index_o, bus3.ack_o);
    end
    bus3.req_i   = 8'b0100_0000;
    bus3.ready_i = 1'b1;
    tick();
    checks++;
    if (bus3.valid_o !== 1'b1 || bus3.index_o !== 3'd6 || bus3.ack_o !== 8'h40) begin
      errors++;
      $display("FAIL accept_capture: valid=%b index=%0d ack=%h, want 1/6/40",
               bus3.valid_o, bus3.index_o, bus3.ack_o);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_rotation();
    test_backpressure();
    test_drop_after_ack();
    test_decode_inverse();
    test_accept_capture();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
